// File: rtl/inst_prefetch_buf.sv
// Sequential instruction prefetch buffer between the CPU fetch channels and
// instruction memory. Words are streamed from ascending addresses into a small
// FIFO. A request that is off the current stream flushes the buffer and
// restarts the stream at the requested address.
// Optional feature: define INST_PREFETCH_STATS_EN to enable the hit/miss counters;
// otherwise hit_cnt and miss_cnt are tied to 0.
module inst_prefetch_buf #(
   parameter int unsigned DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] cpu_pc,
   input  logic        cpu_req_valid,
   output logic        cpu_req_ready,
   output logic [31:0] cpu_inst,
   output logic        cpu_inst_valid,
   input  logic        cpu_inst_ready,
   output logic [31:0] mem_pc,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   input  logic [31:0] mem_inst,
   input  logic        mem_inst_valid,
   output logic        mem_inst_ready,
   output logic [31:0] hit_cnt,
   output logic [31:0] miss_cnt
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [AW:0] DEPTH_W = DEPTH[AW:0];

   typedef enum logic [1:0] {CIdle, CWait, CResp} cpu_state_e;
   typedef enum logic [1:0] {MIdle, MReq, MResp} mem_state_e;

   cpu_state_e    c_state;
   mem_state_e    m_state;
   logic [31:0]   req_pc;
   logic          flushed;
   logic [31:0]   inflight_pc;
   logic [31:0]   next_fetch_pc;
   logic [31:0]   head_addr;
   logic          stream_valid;
   logic          drop;
   logic [AW:0]   count;
   logic [AW-1:0] rd_ptr;
   logic [31:0]   fifo [DEPTH];

   logic [31:0]   exp_addr;
   logic          flush;
   logic          pop;
   logic          push;
   logic [AW-1:0] wr_idx;

   // Expected stream address and the per-cycle flush/push/pop decisions.
   always_comb begin
      exp_addr = next_fetch_pc;
      if (count != '0) begin
         exp_addr = head_addr;
      end else if (m_state == MResp && !drop) begin
         exp_addr = inflight_pc;
      end
      flush  = (c_state == CWait) && !flushed && (!stream_valid || req_pc != exp_addr);
      pop    = (c_state == CWait) && !flush && (count != '0) && (head_addr == req_pc);
      // A flush in the same cycle discards the returning word.
      push   = (m_state == MResp) && mem_inst_valid && !drop && !flush;
      wr_idx = rd_ptr + count[AW-1:0];
   end

   // CPU-side FSM with registered handshake outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         c_state        <= CIdle;
         cpu_req_ready  <= 1'b0;
         cpu_inst_valid <= 1'b0;
         cpu_inst       <= '0;
         req_pc         <= '0;
         flushed        <= 1'b0;
      end else begin
         case (c_state)
            CIdle: begin
               if (cpu_req_ready && cpu_req_valid) begin
                  req_pc        <= cpu_pc;
                  flushed       <= 1'b0;
                  cpu_req_ready <= 1'b0;
                  c_state       <= CWait;
               end else begin
                  cpu_req_ready <= 1'b1;
               end
            end
            CWait: begin
               if (flush) begin
                  flushed <= 1'b1;
               end
               if (pop) begin
                  cpu_inst       <= fifo[rd_ptr];
                  cpu_inst_valid <= 1'b1;
                  c_state        <= CResp;
               end
            end
            CResp: begin
               if (cpu_inst_ready) begin
                  cpu_inst_valid <= 1'b0;
                  cpu_req_ready  <= 1'b1;
                  c_state        <= CIdle;
               end
            end
            default: c_state <= CIdle;
         endcase
      end
   end

   // Memory-side FSM: one outstanding request, stale responses dropped after a flush.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_state        <= MIdle;
         mem_req_valid  <= 1'b0;
         mem_pc         <= '0;
         mem_inst_ready <= 1'b0;
         inflight_pc    <= '0;
         next_fetch_pc  <= '0;
         drop           <= 1'b0;
      end else begin
         case (m_state)
            MIdle: begin
               // Not on a flush cycle: next_fetch_pc is about to be replaced.
               if (stream_valid && count < DEPTH_W && !drop && !flush) begin
                  mem_req_valid <= 1'b1;
                  mem_pc        <= next_fetch_pc;
                  m_state       <= MReq;
               end
            end
            MReq: begin
               if (mem_req_ready) begin
                  mem_req_valid  <= 1'b0;
                  mem_inst_ready <= 1'b1;
                  inflight_pc    <= mem_pc;
                  m_state        <= MResp;
                  // A request already doomed by an earlier flush must not advance the stream.
                  if (!drop && !flush) begin
                     next_fetch_pc <= next_fetch_pc + 32'd4;
                  end
               end
            end
            MResp: begin
               if (mem_inst_valid) begin
                  mem_inst_ready <= 1'b0;
                  drop           <= 1'b0;
                  m_state        <= MIdle;
               end
            end
            default: m_state <= MIdle;
         endcase
         if (flush) begin
            next_fetch_pc <= req_pc;
            // A response consumed this very cycle is already discarded; nothing left to drop.
            drop <= (m_state == MReq) || (m_state == MResp && !mem_inst_valid);
         end
      end
   end

   // FIFO occupancy, read pointer and stream head tracking.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count        <= '0;
         rd_ptr       <= '0;
         head_addr    <= '0;
         stream_valid <= 1'b0;
      end else if (flush) begin
         count        <= '0;
         stream_valid <= 1'b1;
      end else begin
         if (push && count == '0) begin
            head_addr <= inflight_pc;
         end
         if (pop) begin
            rd_ptr    <= rd_ptr + AW'(1);
            head_addr <= head_addr + 32'd4;
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // FIFO storage; data needs no reset since occupancy guards every read.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo[wr_idx] <= mem_inst;
      end
   end

`ifdef INST_PREFETCH_STATS_EN
   logic [31:0] hit_q;
   logic [31:0] miss_q;

   // Wrapping hit/miss counters: miss at flush, hit when an unflushed request completes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hit_q  <= '0;
         miss_q <= '0;
      end else begin
         if (flush) begin
            miss_q <= miss_q + 32'd1;
         end
         if (pop && !flushed) begin
            hit_q <= hit_q + 32'd1;
         end
      end
   end

   assign hit_cnt  = hit_q;
   assign miss_cnt = miss_q;
`else
   assign hit_cnt  = '0;
   assign miss_cnt = '0;
`endif

endmodule

// File: doc/inst_prefetch_buf.md
# inst_prefetch_buf

Sequential instruction prefetch buffer between the CPU instruction fetch channels (request/response handshake pair) and instruction memory. It streams words from ascending addresses into a small FIFO so straight-line fetches hit without waiting on memory. A request to any address off the current stream flushes the buffer and restarts the stream there. One instance sits directly upstream of the CPU's fetch stage, wired to the CPU's PC / Inst_Req / Instruction / Inst_Valid / Inst_Ready ports.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- cpu_pc  in  32  fetch address, word-aligned; sampled on request handshake
- cpu_req_valid  in  1  CPU fetch request
- cpu_req_ready  out  1  buffer accepts request
- cpu_inst  out  32  instruction for the accepted request
- cpu_inst_valid  out  1  cpu_inst valid
- cpu_inst_ready  in  1  CPU takes cpu_inst
- mem_pc  out  32  memory fetch address
- mem_req_valid  out  1  memory request
- mem_req_ready  in  1  memory accepts request
- mem_inst  in  32  memory read data
- mem_inst_valid  in  1  memory data valid
- mem_inst_ready  out  1  buffer accepts data
- hit_cnt  out  32  requests served without flush
- miss_cnt  out  32  requests that caused a flush

## Operation
- FIFO entries hold instruction words only. Entry i sits at head_addr + 4*i. Tracked state: count (0..DEPTH), head_addr, next_fetch_pc, stream_valid, drop.
- Expected address E:
  - head_addr if count>0;
  - else the in-flight request address if one exists and drop=0;
  - else next_fetch_pc.
- CPU FSM:
  - C_IDLE: cpu_req_ready=1. On cpu_req_valid, latch req_pc and go to C_WAIT.
  - C_WAIT: if stream_valid=0 or req_pc≠E, flush (once per request). If count>0 and head_addr==req_pc, pop head into the cpu_inst register and go to C_RESP. Otherwise stay.
  - C_RESP: cpu_inst_valid=1, cpu_inst held stable. On cpu_inst_ready, go to C_IDLE.
- Flush:
  - count←0; next_fetch_pc←req_pc; stream_valid←1.
  - If the memory FSM is in M_REQ or M_RESP, set drop←1.
  - miss_cnt+1. A request completed without flush gives hit_cnt+1, counted at the C_WAIT→C_RESP transition.
- Memory FSM (at most one outstanding):
  - M_IDLE: if stream_valid and count<DEPTH, go to M_REQ.
  - M_REQ: mem_req_valid=1, mem_pc=next_fetch_pc, both held until accepted. On mem_req_ready, go to M_RESP and set next_fetch_pc+=4, except when a flush occurs the same cycle (flush value wins).
  - M_RESP: mem_inst_ready=1. On mem_inst_valid: if drop, discard and clear drop; else push the word (head_addr←address if count was 0). Go to M_IDLE.
- Push and pop in the same cycle leave count unchanged. A flush in the same cycle as a push discards the pushed word.
- Address arithmetic is modulo 2^32; next_fetch_pc wraps from 0xFFFFFFFC to 0.

## Timing
- Reset values: cpu_req_ready=0 while rst=0 and 1 from the first cycle after release; all other outputs 0, including counters. Also count=0, stream_valid=0, drop=0, both FSMs idle.
- Reset mid-transaction abandons everything. Memory must be reset by the same rst.
- Hit latency: with the handshake in cycle T, cpu_inst_valid is high in cycle T+2.
- Miss latency: with memory handshakes completing in one cycle each, cpu_inst_valid goes high no earlier than T+5.
- No combinational path from any input to cpu_req_ready, mem_req_valid, or mem_inst_ready.
- While drop=1 no new memory request is issued. A post-flush refill starts the cycle after the dropped response is consumed.

## Configuration
- INST_PREFETCH_STATS_EN defined: hit_cnt and miss_cnt are live 32-bit wrapping counters.
- Not defined: counter logic is removed and hit_cnt and miss_cnt are tied to 0.

## Test plan
- Reset, then request 0x1000 with zero-latency memory → miss_cnt=1. Memory sees 0x1000, 0x1004, 0x1008, 0x100C; further prefetch stops at count=DEPTH=4.
- Sequential requests 0x1004, 0x1008 after fill → each returns its word at T+2; hit_cnt=2, no extra memory requests beyond refilling freed slots.
- Request 0x2000 while the fetch to 0x1010 is in flight → that response is discarded; next mem_pc=0x2000; cpu_inst equals mem word 0x2000; miss_cnt increments by 1.
- Hold cpu_inst_ready=0 for 10 cycles → cpu_inst_valid stays 1 and cpu_inst stays stable; memory fills to count=4 and then idles.
- Request 0xFFFFFFFC → prefetch continues at 0x00000000; a following request to 0x00000000 is a hit.
- Assert rst=0 during M_RESP → all outputs go to 0 immediately. After release, the first request behaves as the first scenario.
